// File: rtl/dma_copy_engine.sv
// dma_copy_engine: Avalon-MM register slave plus a single-master word copier.
// The slave side holds the transfer setup; the master side performs one read
// and one write per 32-bit word until the programmed byte length runs out.
module dma_copy_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            slave_address,
  input  logic                  slave_chipselect,
  input  logic                  slave_write,
  input  logic                  slave_read,
  input  logic [31:0]           slave_writedata,
  output logic [31:0]           slave_readdata,
  output logic                  slave_waitrequest,
  output logic [ADDR_WIDTH-1:0] master_address,
  output logic                  master_read,
  output logic                  master_write,
  output logic [DATA_WIDTH-1:0] master_writedata,
  input  logic [DATA_WIDTH-1:0] master_readdata,
  input  logic                  master_waitrequest,
  output logic                  irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic [4:0] OFS_STATUS  = 5'd0;
  localparam logic [4:0] OFS_RDADDR  = 5'd4;
  localparam logic [4:0] OFS_WRADDR  = 5'd8;
  localparam logic [4:0] OFS_LENGTH  = 5'd12;
  localparam logic [4:0] OFS_CONTROL = 5'd24;

  localparam int CTRL_GO   = 3;
  localparam int CTRL_IEN  = 4;
  localparam int CTRL_RCON = 8;
  localparam int CTRL_WCON = 9;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LEN_WIDTH-1:0]  length_reg, length_next;
  logic [31:0]           control_reg, control_next;
  logic                  done_reg, done_next;
  logic                  len_reg, len_next;
  logic                  irq_reg;
  logic                  rd_pending_reg;
  logic [31:0]           readdata_reg;
  logic [31:0]           reg_rdata;
  logic                  m_read_reg, m_read_next;
  logic                  m_write_reg, m_write_next;
  logic [ADDR_WIDTH-1:0] m_addr_reg, m_addr_next;
  logic [DATA_WIDTH-1:0] buffer_reg, buffer_next;

  logic busy;
  logic cfg_sel;
  logic wr_stall;
  logic rd_stall;
  logic wr_accept;
  logic rd_first;

  assign busy    = (state_reg != ST_IDLE);
  // Setup registers may not change under a running copy; status may.
  assign cfg_sel = (slave_address == OFS_RDADDR) || (slave_address == OFS_WRADDR) ||
                   (slave_address == OFS_LENGTH) || (slave_address == OFS_CONTROL);

  assign wr_stall  = slave_chipselect & slave_write & busy & cfg_sel;
  assign rd_first  = slave_chipselect & slave_read & ~rd_pending_reg;
  assign rd_stall  = rd_first;
  assign wr_accept = slave_chipselect & slave_write & ~wr_stall;

  assign slave_waitrequest = wr_stall | rd_stall;
  assign slave_readdata    = readdata_reg;
  assign master_address    = m_addr_reg;
  assign master_read       = m_read_reg;
  assign master_write      = m_write_reg;
  assign master_writedata  = buffer_reg;
  assign irq               = irq_reg;

  // Register read mux; pointers and length are shown live.
  always_comb begin
    reg_rdata = '0;
    case (slave_address)
      OFS_STATUS:  reg_rdata = {28'd0, len_reg, 1'b0, busy, done_reg};
      OFS_RDADDR:  reg_rdata = 32'(rd_ptr_reg);
      OFS_WRADDR:  reg_rdata = 32'(wr_ptr_reg);
      OFS_LENGTH:  reg_rdata = 32'(length_reg);
      OFS_CONTROL: reg_rdata = control_reg;
      default:     reg_rdata = '0;
    endcase
  end

  // Next-state logic: slave writes first, engine completion afterwards so a
  // finishing copy overrides a coincident status clear.
  always_comb begin
    state_next   = state_reg;
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    length_next  = length_reg;
    control_next = control_reg;
    done_next    = done_reg;
    len_next     = len_reg;
    m_read_next  = m_read_reg;
    m_write_next = m_write_reg;
    m_addr_next  = m_addr_reg;
    buffer_next  = buffer_reg;

    if (wr_accept) begin
      case (slave_address)
        OFS_STATUS: begin
          done_next = 1'b0;
          len_next  = 1'b0;
        end
        OFS_RDADDR: rd_ptr_next = ADDR_WIDTH'(slave_writedata);
        OFS_WRADDR: wr_ptr_next = ADDR_WIDTH'(slave_writedata);
        OFS_LENGTH: length_next = {slave_writedata[LEN_WIDTH-1:2], 2'b00};
        OFS_CONTROL: begin
          control_next = slave_writedata;
          if (slave_writedata[CTRL_GO]) begin
            done_next = 1'b0;
            len_next  = 1'b0;
            if (length_reg != '0) begin
              state_next  = ST_RD;
              m_read_next = 1'b1;
              m_addr_next = rd_ptr_reg;
            end else begin
              done_next = 1'b1;
              len_next  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    case (state_reg)
      ST_RD: begin
        if (!master_waitrequest) begin
          buffer_next  = master_readdata;
          state_next   = ST_WR;
          m_read_next  = 1'b0;
          m_write_next = 1'b1;
          m_addr_next  = wr_ptr_reg;
        end
      end
      ST_WR: begin
        if (!master_waitrequest) begin
          length_next  = length_reg - LEN_WIDTH'(4);
          m_write_next = 1'b0;
          if (!control_reg[CTRL_RCON]) rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(4);
          if (!control_reg[CTRL_WCON]) wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(4);
          if (length_next == '0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
            len_next   = 1'b1;
          end else begin
            state_next  = ST_RD;
            m_read_next = 1'b1;
            m_addr_next = rd_ptr_next;
          end
        end
      end
      default: ;
    endcase
  end

  // State, datapath and registered master outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      length_reg  <= '0;
      control_reg <= '0;
      done_reg    <= 1'b0;
      len_reg     <= 1'b0;
      m_read_reg  <= 1'b0;
      m_write_reg <= 1'b0;
      m_addr_reg  <= '0;
      buffer_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      length_reg  <= length_next;
      control_reg <= control_next;
      done_reg    <= done_next;
      len_reg     <= len_next;
      m_read_reg  <= m_read_next;
      m_write_reg <= m_write_next;
      m_addr_reg  <= m_addr_next;
      buffer_reg  <= buffer_next;
    end
  end

  // Two-cycle slave read: capture data on the first cycle, release on the second.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_reg <= 1'b0;
      readdata_reg   <= '0;
    end else begin
      rd_pending_reg <= rd_first;
      if (rd_first) readdata_reg <= reg_rdata;
    end
  end

  // Interrupt follows DONE by one cycle when enabled.
  always_ff @(posedge clk) begin
    if (reset) irq_reg <= 1'b0;
    else       irq_reg <= done_reg & control_reg[CTRL_IEN];
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed stimulus with a scoreboard of expected master
// transactions, a wait-state memory model and register read-back checks.
module tb_dma_copy_engine;

  logic        clk;
  logic        reset;
  logic [4:0]  slave_address;
  logic        slave_chipselect;
  logic        slave_write;
  logic        slave_read;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [31:0] master_readdata;
  logic        master_waitrequest;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;
  xact_t sb[$];

  int unsigned mem_waits = 0;
  int unsigned wait_cnt = 0;
  int unsigned wr_count = 0;
  int unsigned snap_wr_count = 0;

  dma_copy_engine dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_chipselect(slave_chipselect),
    .slave_write(slave_write), .slave_read(slave_read),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .slave_waitrequest(slave_waitrequest),
    .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_writedata(master_writedata),
    .master_readdata(master_readdata), .master_waitrequest(master_waitrequest),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory model: each access stalls for mem_waits cycles, then completes.
  assign master_readdata    = pat(master_address);
  assign master_waitrequest = (master_read | master_write) && (wait_cnt < mem_waits);

  always @(posedge clk) begin
    if ((master_read | master_write) && master_waitrequest) wait_cnt <= wait_cnt + 1;
    else                                                    wait_cnt <= 0;
    if (master_write && !master_waitrequest) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [4:0] a, input logic [31:0] d, output int stalls);
    slave_chipselect = 1'b1; slave_write = 1'b1;
    slave_address = a; slave_writedata = d;
    stalls = 0;
    @(negedge clk);
    while (slave_waitrequest && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    check1("wr_timeout", slave_waitrequest, 1'b0);
    @(posedge clk); #1;
    slave_chipselect = 1'b0; slave_write = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    int st;
    sw(a, d, st);
  endtask

  task automatic sr(input logic [4:0] a, output logic [31:0] d);
    slave_chipselect = 1'b1; slave_read = 1'b1; slave_address = a;
    @(negedge clk);
    snap_wr_count = wr_count;
    check1("rd_cyc1_wait", slave_waitrequest, 1'b1);
    @(negedge clk);
    check1("rd_cyc2_wait", slave_waitrequest, 1'b0);
    d = slave_readdata;
    @(posedge clk); #1;
    slave_chipselect = 1'b0; slave_read = 1'b0;
  endtask

  task automatic push_copy(input logic [31:0] rd_a, input logic [31:0] wr_a,
                           input int words, input bit rcon, input bit wcon);
    xact_t e;
    logic [31:0] r, w;
    r = rd_a; w = wr_a;
    for (int i = 0; i < words; i++) begin
      e.is_wr = 1'b0; e.addr = r; e.data = '0;     sb.push_back(e);
      e.is_wr = 1'b1; e.addr = w; e.data = pat(r); sb.push_back(e);
      if (!rcon) r = r + 32'd4;
      if (!wcon) w = w + 32'd4;
    end
  endtask

  // Bus monitor: scoreboard pops, strobe exclusivity and stall stability.
  task automatic monitor_loop();
    logic        stalled, p_rd, p_wr;
    logic [31:0] p_addr, p_data;
    xact_t       e;
    stalled = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check1("hold_read", master_read, p_rd);
          check1("hold_write", master_write, p_wr);
          check("hold_addr", master_address, p_addr);
          check("hold_wdata", master_writedata, p_data);
        end
        if (master_read | master_write) begin
          check1("rd_wr_excl", master_read & master_write, 1'b0);
          if (!master_waitrequest) begin
            total++;
            assert (sb.size() > 0) else begin
              bad++;
              $error("FAIL unexpected_xact: got wr=%b addr=0x%08h expected none",
                     master_write, master_address);
            end
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check1("xact_kind", master_write, e.is_wr);
              check("xact_addr", master_address, e.addr);
              if (e.is_wr) check("xact_data", master_writedata, e.data);
              $display("xact %s addr=0x%08h data=0x%08h", master_write ? "WR" : "RD",
                       master_address, master_write ? master_writedata : master_readdata);
            end
          end
        end
        stalled = (master_read | master_write) & master_waitrequest;
        p_rd = master_read; p_wr = master_write;
        p_addr = master_address; p_data = master_writedata;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int          st;
    int unsigned base;
    int unsigned exp_len;
    logic        seen12, seen8, seen4;

    reset = 1'b1;
    slave_address = '0; slave_chipselect = 1'b0; slave_write = 1'b0;
    slave_read = 1'b0; slave_writedata = '0;
    fork
      monitor_loop();
    join_none

    // Reset state
    tick(3);
    check("rst_readdata", slave_readdata, 32'h0);
    check1("rst_waitreq", slave_waitrequest, 1'b0);
    check1("rst_mread", master_read, 1'b0);
    check1("rst_mwrite", master_write, 1'b0);
    check("rst_maddr", master_address, 32'h0);
    check("rst_mwdata", master_writedata, 32'h0);
    check1("rst_irq", irq, 1'b0);
    reset = 1'b0;
    tick(1);
    sr(5'd0, d);  check("rst_status", d, 32'h0);

    // 1: RCON copy of 4 words, zero waits
    mem_waits = 0;
    wr(5'd4, 32'h100); wr(5'd8, 32'h200); wr(5'd12, 32'd16);
    push_copy(32'h100, 32'h200, 4, 1'b1, 1'b0);
    wr(5'd24, 32'h14C);
    tick(8);
    sr(5'd0, d);  check("t1_status", d, 32'h9);
    check1("t1_irq", irq, 1'b0);
    check("t1_sb_empty", 32'(sb.size()), 32'h0);
    sr(5'd24, d); check("t1_control", d, 32'h14C);
    sr(5'd4, d);  check("t1_rdaddr", d, 32'h100);
    sr(5'd8, d);  check("t1_wraddr", d, 32'h210);
    sr(5'd12, d); check("t1_length", d, 32'h0);

    // 2: GO|I_EN, 2 words, 3 wait states per access
    mem_waits = 3;
    wr(5'd4, 32'h300); wr(5'd8, 32'h400); wr(5'd12, 32'd8);
    push_copy(32'h300, 32'h400, 2, 1'b0, 1'b0);
    wr(5'd24, 32'h18);
    tick(15);
    check1("t2_irq_before", irq, 1'b0);
    tick(1);
    sr(5'd0, d);  check("t2_status_done", d, 32'h9);
    check1("t2_irq_set", irq, 1'b1);
    check("t2_sb_empty", 32'(sb.size()), 32'h0);
    wr(5'd0, 32'h0);
    tick(1);
    check1("t2_irq_clr", irq, 1'b0);
    sr(5'd0, d);  check("t2_status_clr", d, 32'h0);

    // 3: zero length, then sub-word length rounding
    mem_waits = 0;
    wr(5'd12, 32'd0);
    wr(5'd24, 32'h08);
    sr(5'd0, d);  check("t3_status_len0", d, 32'h9);
    check("t3_sb_empty0", 32'(sb.size()), 32'h0);
    wr(5'd12, 32'd7);
    sr(5'd12, d); check("t3_len_round", d, 32'h4);
    wr(5'd4, 32'h500); wr(5'd8, 32'h600);
    push_copy(32'h500, 32'h600, 1, 1'b0, 1'b0);
    wr(5'd24, 32'h08);
    tick(4);
    check("t3_sb_empty1", 32'(sb.size()), 32'h0);
    sr(5'd0, d);  check("t3_status", d, 32'h9);
    sr(5'd4, d);  check("t3_rdaddr", d, 32'h504);

    // 4a: live length and BUSY during a stalled 4-word copy
    mem_waits = 3;
    wr(5'd4, 32'h700); wr(5'd8, 32'h800); wr(5'd12, 32'd16);
    push_copy(32'h700, 32'h800, 4, 1'b0, 1'b0);
    base = wr_count;
    seen12 = 1'b0; seen8 = 1'b0; seen4 = 1'b0;
    wr(5'd24, 32'h08);
    for (int i = 0; i < 16; i++) begin
      sr(5'd12, d);
      exp_len = 16 - 4 * (snap_wr_count - base);
      check("t4_live_len", d, 32'(exp_len));
      if (d == 32'd12) seen12 = 1'b1;
      if (d == 32'd8)  seen8  = 1'b1;
      if (d == 32'd4)  seen4  = 1'b1;
      sr(5'd0, d);
      exp_len = 16 - 4 * (snap_wr_count - base);
      check("t4_live_status", d, (exp_len != 0) ? 32'h2 : 32'h9);
      if (exp_len == 0) break;
    end
    check1("t4_saw_12", seen12, 1'b1);
    check1("t4_saw_8", seen8, 1'b1);
    check1("t4_saw_4", seen4, 1'b1);
    check("t4a_sb_empty", 32'(sb.size()), 32'h0);

    // 4b: length write stalls until the copy finishes
    mem_waits = 0;
    wr(5'd4, 32'h900); wr(5'd8, 32'hA00); wr(5'd12, 32'd16);
    push_copy(32'h900, 32'hA00, 4, 1'b0, 1'b0);
    wr(5'd24, 32'h08);
    sw(5'd12, 32'd40, st);
    check("t4_len_stalls", 32'(st), 32'd8);
    sr(5'd12, d); check("t4_len_after", d, 32'd40);
    check("t4b_sb_empty", 32'(sb.size()), 32'h0);
    sr(5'd0, d);  check("t4b_status", d, 32'h9);

    // 5: reset during WR of word 2
    wr(5'd4, 32'hB00); wr(5'd8, 32'hC00); wr(5'd12, 32'd16);
    push_copy(32'hB00, 32'hC00, 1, 1'b0, 1'b0);
    push_copy(32'hB04, 32'hC04, 1, 1'b0, 1'b0);
    void'(sb.pop_back());
    wr(5'd24, 32'h08);
    tick(3);
    reset = 1'b1;
    @(negedge clk);
    check1("t5_in_wr2", master_write, 1'b1);
    check("t5_wr2_addr", master_address, 32'hC04);
    @(posedge clk); #1;
    check1("t5_mwrite_rst", master_write, 1'b0);
    check1("t5_mread_rst", master_read, 1'b0);
    reset = 1'b0;
    sr(5'd0, d);  check("t5_status", d, 32'h0);
    sr(5'd12, d); check("t5_length", d, 32'h0);
    sr(5'd4, d);  check("t5_rdaddr", d, 32'h0);
    check("t5_sb_empty0", 32'(sb.size()), 32'h0);
    wr(5'd4, 32'hD00); wr(5'd8, 32'hE00); wr(5'd12, 32'd8);
    push_copy(32'hD00, 32'hE00, 2, 1'b0, 1'b0);
    wr(5'd24, 32'h08);
    tick(6);
    check("t5_sb_empty1", 32'(sb.size()), 32'h0);
    sr(5'd0, d);  check("t5_status_done", d, 32'h9);

    // 6: WCON with read-pointer wrap; status write mid-copy is not stalled
    wr(5'd4, 32'hFFFF_FFF8); wr(5'd8, 32'hFFFF_FFFC); wr(5'd12, 32'd12);
    push_copy(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1'b0, 1'b1);
    wr(5'd24, 32'h208);
    sw(5'd0, 32'h0, st);
    check("t6_status_stalls", 32'(st), 32'd0);
    tick(8);
    check("t6_sb_empty", 32'(sb.size()), 32'h0);
    sr(5'd4, d);  check("t6_rdaddr_wrap", d, 32'h4);
    sr(5'd8, d);  check("t6_wraddr", d, 32'hFFFF_FFFC);
    sr(5'd0, d);  check("t6_status", d, 32'h9);

    // Unmapped offsets
    wr(5'd16, 32'hDEAD_BEEF);
    sr(5'd16, d); check("unmapped_16", d, 32'h0);
    sr(5'd20, d); check("unmapped_20", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
